// File: rtl/contador_bcd_asc_lim_pkg.sv
// Shared constants, state encoding and digit helpers for the two-digit BCD up-counter.
// Combinational helpers only; no latency and no flow control.
package contador_bcd_asc_lim_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] RST_VAL = 8'h00;

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    // Out-of-range limit digits saturate so the compare stays within 00..99.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Out-of-range load digits collapse to zero so the counter never holds a non-BCD value.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/contador_bcd_asc_lim_digito.sv
// One BCD digit: load, wrap-to-zero or increment when enabled with an incoming carry.
// One-cycle registered update; no backpressure, carry_out is combinational from the digit.
module digito_bcd_asc
    import contador_bcd_asc_lim_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       carry_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       wrap,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= RST_VAL[3:0];
        end else if (load) begin
            r_digit <= sanitize_digit(load_digit);
        end else if (wrap) begin
            r_digit <= 4'd0;
        end else if (en && carry_in) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit     = r_digit;
    assign carry_out = (r_digit == BCD_MAX) && en;

endmodule

// File: rtl/contador_bcd_asc_lim.sv
// Two-digit BCD up-counter with start/stop control, load and a selectable wrap limit.
// One-cycle latency from every input to every output; no backpressure, all outputs registered.
module contador_bcd_asc_lim
    import contador_bcd_asc_lim_pkg::*;
#(
    parameter logic [7:0] LIM_DEFAULT = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] lim,
    input  logic       lim_valid,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       tc,
    output logic       running
);

    estado_t r_state;
    logic    r_running;
    logic    r_tc;

    logic [7:0] w_lim_sel;
    logic [7:0] w_lim_eff;
    logic       w_inc;
    logic       w_at_lim;
    logic       w_wrap;
    logic       w_cy_units;
    logic       w_cy_tens;

    assign w_lim_sel = lim_valid ? lim : LIM_DEFAULT;
    assign w_lim_eff = {clamp_digit(w_lim_sel[7:4]), clamp_digit(w_lim_sel[3:0])};

    // Valid BCD orders the same as binary, so a plain compare suffices.
    assign w_inc    = tick && (r_state == CONTANDO) && !load;
    assign w_at_lim = ({tens, units} >= w_lim_eff);
    assign w_wrap   = w_inc && (w_at_lim || (w_cy_units && w_cy_tens));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= PARADO;
            r_running <= 1'b0;
        end else if (stop) begin
            r_state   <= PARADO;
            r_running <= 1'b0;
        end else if (start) begin
            r_state   <= CONTANDO;
            r_running <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_wrap;
        end
    end

    digito_bcd_asc u_units (
        .clk        (clk),
        .reset      (reset),
        .en         (w_inc),
        .carry_in   (1'b1),
        .load       (load),
        .load_digit (load_val[3:0]),
        .wrap       (w_wrap),
        .digit      (units),
        .carry_out  (w_cy_units)
    );

    digito_bcd_asc u_tens (
        .clk        (clk),
        .reset      (reset),
        .en         (w_inc),
        .carry_in   (w_cy_units),
        .load       (load),
        .load_digit (load_val[7:4]),
        .wrap       (w_wrap),
        .digit      (tens),
        .carry_out  (w_cy_tens)
    );

    assign tc      = r_tc;
    assign running = r_running;

endmodule

// File: tb/tb_contador_bcd_asc_lim.sv
// Directed scenarios followed by random traffic, compared against a decimal reference model.
module tb_contador_bcd_asc_lim;

    localparam logic [7:0] LIM_DEF = 8'h59;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, tick, load, lim_valid;
    logic [7:0] load_val, lim;
    logic [3:0] units, tens;
    logic       tc, running;

    int checks = 0;
    int errors = 0;

    int m_val;
    bit m_run;
    bit m_tc;

    logic [7:0] cur_lim;
    bit         cur_lv;

    contador_bcd_asc_lim #(.LIM_DEFAULT(LIM_DEF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .load      (load),
        .load_val  (load_val),
        .lim       (lim),
        .lim_valid (lim_valid),
        .units     (units),
        .tens      (tens),
        .tc        (tc),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic int dig_load(input logic [3:0] d);
        return (d > 4'd9) ? 0 : int'(d);
    endfunction

    function automatic int lim_dec(input logic [7:0] l);
        int t;
        int u;
        t = int'(l[7:4]);
        u = int'(l[3:0]);
        if (t > 9) t = 9;
        if (u > 9) u = 9;
        return t * 10 + u;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".units"},   {4'h0, units},   8'(m_val % 10));
        chk({tag, ".tens"},    {4'h0, tens},    8'(m_val / 10));
        chk({tag, ".tc"},      {7'h0, tc},      {7'h0, m_tc});
        chk({tag, ".running"}, {7'h0, running}, {7'h0, m_run});
    endtask

    task automatic model_reset();
        m_val = 0;
        m_run = 1'b0;
        m_tc  = 1'b0;
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check 1ns later.
    task automatic cyc(input bit st, input bit sp, input bit tk, input bit ld,
                       input logic [7:0] ldv, input logic [7:0] lm, input bit lv,
                       input string tag);
        int lmt;
        start = st; stop = sp; tick = tk; load = ld;
        load_val = ldv; lim = lm; lim_valid = lv;
        @(posedge clk);
        lmt = lv ? lim_dec(lm) : lim_dec(LIM_DEF);
        if (ld) begin
            m_val = dig_load(ldv[7:4]) * 10 + dig_load(ldv[3:0]);
            m_tc  = 1'b0;
        end else if (tk && m_run) begin
            if (m_val >= lmt) begin
                m_val = 0;
                m_tc  = 1'b1;
            end else begin
                m_val = m_val + 1;
                m_tc  = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
        if (sp) m_run = 1'b0;
        else if (st) m_run = 1'b1;
        #1;
        chk_all(tag);
        @(negedge clk);
    endtask

    task automatic do_start(input string tag);
        cyc(1, 0, 0, 0, 8'h00, cur_lim, cur_lv, tag);
    endtask

    task automatic do_stop(input string tag);
        cyc(0, 1, 0, 0, 8'h00, cur_lim, cur_lv, tag);
    endtask

    task automatic do_load(input logic [7:0] v, input string tag);
        cyc(0, 0, 0, 1, v, cur_lim, cur_lv, tag);
    endtask

    task automatic do_ticks(input int n, input string tag, output int tc_cnt, output int tc_idx);
        tc_cnt = 0;
        tc_idx = -1;
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1, 0, 8'h00, cur_lim, cur_lv, tag);
            if (tc === 1'b1) begin
                tc_cnt++;
                if (tc_idx < 0) tc_idx = i;
            end
        end
    endtask

    initial begin
        int n_tc;
        int i_tc;
        reset = 1'b0;
        start = 0; stop = 0; tick = 0; load = 0;
        load_val = 8'h00; lim = 8'h00; lim_valid = 0;
        cur_lim = 8'h00; cur_lv = 1'b0;
        model_reset();
        #3;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Default limit: 00..59 then wrap, single tc after the tick taken at 59.
        do_start("dflt.start");
        do_ticks(60, "dflt", n_tc, i_tc);
        chk("dflt.tc_count", 8'(n_tc), 8'd1);
        chk("dflt.tc_index", 8'(i_tc), 8'd59);
        chk("dflt.final", {tens, units}, 8'h00);

        // Custom limit 12, then an out-of-range limit clamped to 39.
        cur_lim = 8'h12; cur_lv = 1'b1;
        do_ticks(13, "lim12", n_tc, i_tc);
        chk("lim12.tc_count", 8'(n_tc), 8'd1);
        chk("lim12.tc_index", 8'(i_tc), 8'd12);
        cur_lim = 8'h3F;
        do_ticks(40, "lim3F", n_tc, i_tc);
        chk("lim3F.tc_count", 8'(n_tc), 8'd1);
        chk("lim3F.tc_index", 8'(i_tc), 8'd39);

        // Limit lowered below the current value.
        do_load(8'h45, "low.load");
        do_start("low.start");
        cur_lim = 8'h20;
        cyc(0, 0, 1, 0, 8'h00, cur_lim, cur_lv, "low.tick");
        chk("low.value", {tens, units}, 8'h00);
        chk("low.tc", {7'h0, tc}, 8'h01);

        // Simultaneous start/stop, then a load overriding a tick.
        do_stop("sim.stop");
        cyc(1, 1, 0, 0, 8'h00, cur_lim, cur_lv, "sim.startstop");
        chk("sim.running", {7'h0, running}, 8'h00);
        do_start("sim.start");
        cur_lim = 8'h99;
        cyc(0, 0, 1, 1, 8'h7A, cur_lim, cur_lv, "sim.loadtick");
        chk("sim.load7A", {tens, units}, 8'h70);
        chk("sim.tc", {7'h0, tc}, 8'h00);

        // Ticks ignored while stopped; stop mid-count holds the value.
        do_stop("idle.stop");
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'h00, cur_lim, cur_lv, "idle.tick");
        chk("idle.value", {tens, units}, 8'h70);
        do_load(8'h30, "hold.load");
        do_start("hold.start");
        do_ticks(3, "hold.count", n_tc, i_tc);
        do_stop("hold.stop");
        do_ticks(5, "hold.ticks", n_tc, i_tc);
        chk("hold.value", {tens, units}, 8'h33);

        // Asynchronous reset between edges with a wrap pending at 57.
        cur_lim = 8'h57;
        do_load(8'h57, "arst.load");
        do_start("arst.start");
        tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("arst.async");
        @(negedge clk);
        reset = 1'b1;
        do_ticks(6, "arst.after", n_tc, i_tc);
        chk("arst.tc_count", 8'(n_tc), 8'd0);

        // Random traffic, including non-BCD load values and limits.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0,
                ($urandom % 16) == 0, 8'($urandom), 8'($urandom), ($urandom % 2) == 0,
                "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
